// File: rtl/rtc_alm_pkg.sv
// Shared definitions for the RTC alarm bank: register map, CTRL layout, modes, time layout.
// RTC_ALM_COUNTDOWN_EN widens the writable CTRL bits to include the countdown reload field.
package rtc_alm_pkg;

    localparam logic [4:0] ADDR_INTR_EN  = 5'h10;
    localparam logic [4:0] ADDR_INTR_STS = 5'h11;

    localparam int unsigned CTRL_EN         = 0;
    localparam int unsigned CTRL_MODE_LSB   = 1;
    localparam int unsigned CTRL_MASK_LSB   = 4;
    localparam int unsigned CTRL_DY         = 8;
    localparam int unsigned CTRL_RELOAD_LSB = 16;

    localparam int unsigned MASK_SEC  = 0;
    localparam int unsigned MASK_MIN  = 1;
    localparam int unsigned MASK_HOUR = 2;
    localparam int unsigned MASK_DAY  = 3;

`ifdef RTC_ALM_COUNTDOWN_EN
    localparam logic [31:0] CTRL_WMASK = 32'hFFFF_01F7;
`else
    localparam logic [31:0] CTRL_WMASK = 32'h0000_01F7;
`endif

    typedef enum logic [1:0] {
        MODE_ONESHOT   = 2'd0,
        MODE_REPEAT    = 2'd1,
        MODE_COUNTDOWN = 2'd2,
        MODE_RSVD      = 2'd3
    } alm_mode_e;

    typedef struct packed {
        logic [4:0] pad3;
        logic [2:0] dow;
        logic [1:0] pad2;
        logic [1:0] th;
        logic [3:0] h;
        logic       pad1;
        logic [2:0] tm;
        logic [3:0] m;
        logic       pad0;
        logic [2:0] ts;
        logic [3:0] s;
    } rtc_time_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int unsigned b = 0; b < 4; b++)
            res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/rtc_alm_chan.sv
// One alarm channel: TIME/CTRL registers, field compare, mode handling and countdown.
// The countdown counter exists only when RTC_ALM_COUNTDOWN_EN is defined.
module rtc_alm_chan
    import rtc_alm_pkg::*;
(
    input  logic        rtc_clk,
    input  logic        rst,
    input  logic        chk,
    input  logic [31:0] cur_time,
    input  logic [7:0]  cur_date,
    input  logic        time_we,
    input  logic        ctrl_we,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] time_q,
    output logic [31:0] ctrl_q,
    output logic        fire
);

    logic [31:0] time_r;
    logic [31:0] ctrl_r;
    logic [31:0] ctrl_nxt;
    rtc_time_t   now;
    rtc_time_t   alm;
    alm_mode_e   mode;
    logic        en;
    logic [3:0]  mask;
    logic        sec_ok, min_ok, hour_ok, day_ok;

    assign time_q   = time_r;
    assign ctrl_q   = ctrl_r;
    assign ctrl_nxt = be_merge(ctrl_r, wdata, be) & CTRL_WMASK;
    assign en       = ctrl_r[CTRL_EN];
    assign mode     = alm_mode_e'(ctrl_r[CTRL_MODE_LSB +: 2]);
    assign mask     = ctrl_r[CTRL_MASK_LSB +: 4];

    // Pad bits are included in the byte compares; they are zero in a well-formed time word.
    always_comb begin
        now     = rtc_time_t'(cur_time);
        alm     = rtc_time_t'(time_r);
        sec_ok  = mask[MASK_SEC]  | ({alm.pad0, alm.ts, alm.s} == {now.pad0, now.ts, now.s});
        min_ok  = mask[MASK_MIN]  | ({alm.pad1, alm.tm, alm.m} == {now.pad1, now.tm, now.m});
        hour_ok = mask[MASK_HOUR] | ({alm.pad2, alm.th, alm.h} == {now.pad2, now.th, now.h});
        if (ctrl_r[CTRL_DY])
            day_ok = mask[MASK_DAY] | ({now.pad3, now.dow} == {5'b0, alm.dow});
        else
            day_ok = mask[MASK_DAY] | ({alm.pad3, alm.dow} == cur_date);
    end

`ifdef RTC_ALM_COUNTDOWN_EN
    logic [15:0] cnt;
    logic        cd_tick;

    assign cd_tick = chk && en && (mode == MODE_COUNTDOWN) && (cnt != 16'd0);

    // A CTRL write outranks the hardware decrement/reload in the same cycle.
    always_ff @(posedge rtc_clk) begin
        if (rst)
            cnt <= '0;
        else if (ctrl_we) begin
            if (ctrl_nxt[CTRL_EN])
                cnt <= ctrl_nxt[CTRL_RELOAD_LSB +: 16];
        end else if (cd_tick)
            cnt <= (cnt == 16'd1) ? ctrl_r[CTRL_RELOAD_LSB +: 16] : cnt - 16'd1;
    end
`endif

    always_comb begin
        fire = 1'b0;
        case (mode)
            MODE_ONESHOT, MODE_REPEAT:
                fire = chk && en && sec_ok && min_ok && hour_ok && day_ok;
`ifdef RTC_ALM_COUNTDOWN_EN
            MODE_COUNTDOWN:
                fire = cd_tick && (cnt == 16'd1);
`endif
            default:
                fire = 1'b0;
        endcase
    end

    always_ff @(posedge rtc_clk) begin
        if (rst) begin
            time_r <= '0;
            ctrl_r <= '0;
        end else begin
            if (time_we)
                time_r <= be_merge(time_r, wdata, be);
            if (ctrl_we)
                ctrl_r <= ctrl_nxt;
            else if (fire && mode == MODE_ONESHOT)
                ctrl_r[CTRL_EN] <= 1'b0;
        end
    end

endmodule

// File: rtl/rtc_alarm_bank.sv
// RTC alarm bank: register decode, NUM_ALM alarm channels, sticky status and interrupt.
// Define RTC_ALM_COUNTDOWN_EN to enable the per-channel countdown mode.
module rtc_alarm_bank
    import rtc_alm_pkg::*;
#(
    parameter int unsigned NUM_ALM = 4
) (
    input  logic               rtc_clk,
    input  logic               rst,
    input  logic               reg_cs,
    input  logic               reg_wr,
    input  logic [4:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    input  logic [3:0]         reg_be,
    output logic [31:0]        reg_rdata,
    output logic               reg_ack,
    input  logic               inc_time_s,
    input  logic [31:0]        cur_time,
    input  logic [7:0]         cur_date,
    output logic               alm_intr,
    output logic [NUM_ALM-1:0] alm_hit
);

    logic               chk;
    logic               access;
    logic               wr_commit;
    logic               en_wr;
    logic               sts_wr;
    logic [NUM_ALM-1:0] intr_en;
    logic [NUM_ALM-1:0] intr_en_nxt;
    logic [NUM_ALM-1:0] sts;
    logic [NUM_ALM-1:0] sts_nxt;
    logic [NUM_ALM-1:0] w1c;
    logic [NUM_ALM-1:0] fire;
    logic [NUM_ALM-1:0] time_we;
    logic [NUM_ALM-1:0] ctrl_we;
    logic [31:0]        time_q [NUM_ALM];
    logic [31:0]        ctrl_q [NUM_ALM];
    logic [31:0]        rd_val;

    assign access    = reg_cs && !reg_ack;
    assign wr_commit = access && reg_wr;
    assign en_wr     = wr_commit && (reg_addr == ADDR_INTR_EN);
    assign sts_wr    = wr_commit && (reg_addr == ADDR_INTR_STS);

    for (genvar g = 0; g < NUM_ALM; g++) begin : g_chan
        assign time_we[g] = wr_commit && (reg_addr == 5'(2*g));
        assign ctrl_we[g] = wr_commit && (reg_addr == 5'(2*g + 1));

        rtc_alm_chan u_chan (
            .rtc_clk  (rtc_clk),
            .rst      (rst),
            .chk      (chk),
            .cur_time (cur_time),
            .cur_date (cur_date),
            .time_we  (time_we[g]),
            .ctrl_we  (ctrl_we[g]),
            .wdata    (reg_wdata),
            .be       (reg_be),
            .time_q   (time_q[g]),
            .ctrl_q   (ctrl_q[g]),
            .fire     (fire[g])
        );
    end

    // Hardware set is OR-ed in after the W1C mask so a coincident fire wins.
    always_comb begin
        intr_en_nxt = (en_wr && reg_be[0]) ? reg_wdata[NUM_ALM-1:0] : intr_en;
        w1c         = (sts_wr && reg_be[0]) ? reg_wdata[NUM_ALM-1:0] : '0;
        sts_nxt     = (sts & ~w1c) | fire;
    end

    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_ALM; i++) begin
            if (reg_addr == 5'(2*i))
                rd_val = time_q[i];
            if (reg_addr == 5'(2*i + 1))
                rd_val = ctrl_q[i];
        end
        if (reg_addr == ADDR_INTR_EN)
            rd_val = 32'(intr_en);
        if (reg_addr == ADDR_INTR_STS)
            rd_val = 32'(sts);
    end

    always_ff @(posedge rtc_clk) begin
        if (rst) begin
            chk       <= 1'b0;
            reg_ack   <= 1'b0;
            reg_rdata <= '0;
            intr_en   <= '0;
            sts       <= '0;
            alm_hit   <= '0;
            alm_intr  <= 1'b0;
        end else begin
            chk       <= inc_time_s;
            reg_ack   <= access;
            reg_rdata <= access ? rd_val : '0;
            intr_en   <= intr_en_nxt;
            sts       <= sts_nxt;
            alm_hit   <= fire;
            alm_intr  <= |(sts_nxt & intr_en_nxt);
        end
    end

endmodule

// File: tb/tb_rtc_alarm_bank.sv
// Directed self-checking bench for rtc_alarm_bank (8 channels); countdown
// expectations follow RTC_ALM_COUNTDOWN_EN.
module tb_rtc_alarm_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs = 1'b0;
    logic        wr = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic [31:0] rdata;
    logic        ack;
    logic        inc = 1'b0;
    logic [31:0] cur_time = '0;
    logic [7:0]  cur_date = '0;
    logic        intr;
    logic [7:0]  hit;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rtc_alarm_bank #(.NUM_ALM(8)) dut (
        .rtc_clk    (clk),
        .rst        (rst),
        .reg_cs     (cs),
        .reg_wr     (wr),
        .reg_addr   (addr),
        .reg_wdata  (wdata),
        .reg_be     (be),
        .reg_rdata  (rdata),
        .reg_ack    (ack),
        .inc_time_s (inc),
        .cur_time   (cur_time),
        .cur_date   (cur_date),
        .alm_intr   (intr),
        .alm_hit    (hit)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; be = '0;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d, output logic k);
        @(negedge clk);
        cs = 1'b1; wr = 1'b0; addr = a;
        @(posedge clk);
        #1;
        d = rdata;
        k = ack;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic tick(output logic [7:0] h);
        @(negedge clk);
        inc = 1'b1;
        @(negedge clk);
        inc = 1'b0;
        @(posedge clk);
        #1;
        h = hit;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        k;
        do_reset();
        @(posedge clk);
        #1;
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rst_ack got %b exp 0", ack); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h exp 0", rdata); end
        n_cmp++; if (hit !== 8'h0) begin n_err++; $display("FAIL rst_hit got %h exp 0", hit); end
        n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL rst_intr got %b exp 0", intr); end
        bus_rd(5'h01, d, k);
        n_cmp++; if (k !== 1'b1) begin n_err++; $display("FAIL rd_ack got %b exp 1", k); end
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_ctrl0 got %h exp 0", d); end
        bus_wr(5'h00, 32'h1234_5678, 4'hF);
        bus_rd(5'h00, d, k);
        n_cmp++; if (d !== 32'h1234_5678) begin n_err++; $display("FAIL time0_rd got %h exp 12345678", d); end
        @(posedge clk);
        #1;
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rdata_idle got %h exp 0", rdata); end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        logic        k;
        logic [7:0]  h;
        do_reset();
        cur_date = 8'h00;
        bus_wr(5'h10, 32'h1, 4'hF);
        bus_wr(5'h00, 32'h0012_3000, 4'hF);
        bus_wr(5'h01, 32'h0000_0001, 4'hF);
        cur_time = 32'h0012_3001;
        tick(h);
        n_cmp++; if (h !== 8'h00) begin n_err++; $display("FAIL os_nomatch got %h exp 00", h); end
        cur_time = 32'h0012_3000;
        tick(h);
        n_cmp++; if (h !== 8'h01) begin n_err++; $display("FAIL os_hit got %h exp 01", h); end
        n_cmp++; if (intr !== 1'b1) begin n_err++; $display("FAIL os_intr got %b exp 1", intr); end
        @(posedge clk);
        #1;
        n_cmp++; if (hit !== 8'h00) begin n_err++; $display("FAIL os_pulse got %h exp 00", hit); end
        bus_rd(5'h11, d, k);
        n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL os_sts got %h exp 1", d); end
        bus_rd(5'h01, d, k);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL os_en_clr got %h exp 0", d); end
        tick(h);
        n_cmp++; if (h !== 8'h00) begin n_err++; $display("FAIL os_refire got %h exp 00", h); end
    endtask

    task automatic test_repeat();
        logic [31:0] d;
        logic        k;
        logic [7:0]  h;
        do_reset();
        cur_date = 8'h99;
        cur_time = 32'h0311_1111;
        bus_wr(5'h00, 32'h0300_0000, 4'hF);
        bus_wr(5'h01, 32'h0000_0173, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick(h);
            n_cmp++; if (h !== 8'h01) begin n_err++; $display("FAIL rep_hit%0d got %h exp 01", i, h); end
            cur_time = cur_time + 32'h1;
        end
        cur_time = 32'h0411_1111;
        tick(h);
        n_cmp++; if (h !== 8'h00) begin n_err++; $display("FAIL rep_dow4 got %h exp 00", h); end
        bus_rd(5'h01, d, k);
        n_cmp++; if (d !== 32'h0000_0173) begin n_err++; $display("FAIL rep_ctrl got %h exp 173", d); end
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        logic        k;
        logic [7:0]  h;
        bus_wr(5'h11, 32'hFF, 4'h1);
        bus_rd(5'h11, d, k);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL w1c_clr got %h exp 0", d); end
        bus_wr(5'h11, 32'h0, 4'h1);
        cur_time = 32'h0300_0000;
        tick(h);
        bus_rd(5'h11, d, k);
        n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL w1c_preset got %h exp 1", d); end
        @(negedge clk);
        inc = 1'b1;
        @(negedge clk);
        inc = 1'b0;
        cs = 1'b1; wr = 1'b1; addr = 5'h11; wdata = 32'h1; be = 4'h1;
        @(posedge clk);
        #1;
        h = hit;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; be = '0;
        n_cmp++; if (h !== 8'h01) begin n_err++; $display("FAIL race_hit got %h exp 01", h); end
        bus_rd(5'h11, d, k);
        n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL race_sts got %h exp 1", d); end
    endtask

    task automatic test_countdown();
        logic [31:0] d;
        logic        k;
        logic [7:0]  h;
        logic [7:0]  e;
        do_reset();
        cur_time = 32'h0;
        bus_wr(5'h01, 32'h0003_0005, 4'hF);
        bus_wr(5'h03, 32'h0000_0005, 4'hF);
        for (int i = 1; i <= 9; i++) begin
            tick(h);
`ifdef RTC_ALM_COUNTDOWN_EN
            e = (i % 3 == 0) ? 8'h01 : 8'h00;
`else
            e = 8'h00;
`endif
            n_cmp++; if (h !== e) begin n_err++; $display("FAIL cd_pulse%0d got %h exp %h", i, h, e); end
        end
        bus_rd(5'h01, d, k);
`ifdef RTC_ALM_COUNTDOWN_EN
        n_cmp++; if (d !== 32'h0003_0005) begin n_err++; $display("FAIL cd_ctrl got %h exp 00030005", d); end
`else
        n_cmp++; if (d !== 32'h0000_0005) begin n_err++; $display("FAIL cd_ctrl got %h exp 00000005", d); end
`endif
    endtask

    task automatic test_all_chan();
        logic [31:0] d;
        logic        k;
        logic [7:0]  h;
        do_reset();
        for (int i = 0; i < 8; i++)
            bus_wr(5'(2*i + 1), 32'h0000_00F3, 4'hF);
        tick(h);
        n_cmp++; if (h !== 8'hFF) begin n_err++; $display("FAIL all_hit got %h exp ff", h); end
        n_cmp++; if (intr !== 1'b0) begin n_err++; $display("FAIL all_intr_gated got %b exp 0", intr); end
        bus_rd(5'h11, d, k);
        n_cmp++; if (d !== 32'hFF) begin n_err++; $display("FAIL all_sts got %h exp ff", d); end
        bus_rd(5'h12, d, k);
        n_cmp++; if (d !== 32'h0 || k !== 1'b1) begin n_err++; $display("FAIL rd_0x12 got %h/%b exp 0/1", d, k); end
        bus_wr(5'h1F, 32'hFFFF_FFFF, 4'hF);
        bus_rd(5'h10, d, k);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL wr1f_inten got %h exp 0", d); end
        bus_rd(5'h0F, d, k);
        n_cmp++; if (d !== 32'hF3) begin n_err++; $display("FAIL wr1f_ctrl7 got %h exp f3", d); end
        bus_rd(5'h00, d, k);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL wr1f_time0 got %h exp 0", d); end
        bus_wr(5'h04, 32'hAABB_CCDD, 4'b0101);
        bus_rd(5'h04, d, k);
        n_cmp++; if (d !== 32'h00BB_00DD) begin n_err++; $display("FAIL be_lane got %h exp 00bb00dd", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        k;
        bus_wr(5'h00, 32'h1234_5678, 4'hF);
        bus_wr(5'h10, 32'h0F, 4'h1);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = 5'h00; wdata = 32'hDEAD_BEEF; be = 4'hF;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL midrst_ack got %b exp 0", ack); end
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; be = '0; rst = 1'b0;
        bus_rd(5'h00, d, k);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL midrst_time0 got %h exp 0", d); end
        bus_rd(5'h10, d, k);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL midrst_inten got %h exp 0", d); end
        bus_rd(5'h11, d, k);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL midrst_sts got %h exp 0", d); end
        bus_rd(5'h0F, d, k);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL midrst_ctrl7 got %h exp 0", d); end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_repeat();
        test_w1c_race();
        test_countdown();
        test_all_chan();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
